round_loop_mux: RTL and testbench
=================================

# round_loop_mux

Registered round-loop selector for the iterative AES datapath. It replaces the plain combinational input/round select with a state register, a round counter and ready/valid handshakes. A block is accepted from the input side and fed to the round logic. The round logic's output is then looped back for a run-time-selected number of rounds (10/12/14 for AES-128/192/256), and the result is presented on an output handshake. It sits between the plaintext/key-whitening stage and the round function, and drives the key schedule's round index.

## Interface
- WIDTH, 128, datapath width in bits
- CW, 4, round counter width; must hold 14
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous abort; highest priority after reset
- in_valid  input  1  datain valid
- in_ready  output  1  block accepted on edge where in_valid & in_ready
- datain  input  WIDTH  new block (already whitened)
- nr_sel  input  2  round count: 00→10, 01→12, 10→14, 11→14; sampled only at accept
- state_out  output  WIDTH  registered state fed to round logic
- rnddata  input  WIDTH  round logic result for current state_out (combinational)
- round_idx  output  CW  current round number to key schedule
- last_round  output  1  current round is final (round logic omits MixColumns)
- out_valid  output  1  dataout valid
- out_ready  input  1  downstream accepts dataout
- dataout  output  WIDTH  result; equals state_out

## Operation
- FSM states: IDLE, RUN, DONE. Internal nr register (CW bits) holds the latched round count.
- IDLE behaviour:
  - in_ready=1.
  - On in_valid: state_out←datain, round_idx←1, nr←decode(nr_sel), go to RUN.
- RUN behaviour:
  - Every edge: state_out←rnddata.
  - If round_idx==nr: go to DONE, round_idx←0.
  - Otherwise: round_idx←round_idx+1.
- last_round = (fsm==RUN) & (round_idx==nr). It is combinational from registers and high for exactly one cycle per block.
- DONE behaviour:
  - out_valid=1; dataout and state_out are held stable until out_ready.
  - On out_ready & !in_valid: go to IDLE.
  - On out_ready & in_valid: accept the new block on the same edge (IDLE load actions) and go to RUN. There is no bubble.
- in_ready = (fsm==IDLE) | (fsm==DONE & out_ready).
- in_valid in RUN, or in DONE without out_ready, is ignored. datain is not captured.
- nr_sel changes outside an accept edge have no effect on a block in flight.
- clr high on an edge: fsm←IDLE, state_out←0, round_idx←0, regardless of handshakes. A transfer that coincides with clr does not happen: no accept, no output consumed.
- round_idx never exceeds nr and never wraps. Counter arithmetic is unsigned in CW bits.

## Timing
- Reset (async assert, in any state):
  - fsm=IDLE, state_out=0, dataout=0, round_idx=0, nr=14.
  - last_round=0, out_valid=0, in_ready=1.
- Release is synchronous to clk; the first accept is possible on the first edge after rst_n rises.
- Accept at edge E:
  - round_idx=1..nr on cycles after edges E..E+nr-1.
  - out_valid high after edge E+nr. Latency from accept to out_valid is nr cycles: 10, 12 or 14.
- Throughput with out_ready held high: one block per nr+1 cycles, including the DONE cycle.
- Reset asserted mid-RUN: outputs go to reset values immediately. No out_valid is produced for the aborted block.

## Test plan
- **Reset:** assert rst_n=0 mid-RUN (round 7) -> immediately state_out=0, round_idx=0, out_valid=0, in_ready=1, last_round=0.
- **AES-256 run:** model rnddata=state_out+1 (mod 2^128); accept datain=0x1000 with nr_sel=10 ->
  - round_idx steps 1..14;
  - last_round high only at round_idx=14;
  - out_valid rises 14 cycles after accept with dataout=0x100E.
- **Round-count modes:**
  - nr_sel=00, datain=0 -> dataout=0xA after 10 cycles.
  - nr_sel=01 -> dataout=0xC after 12 cycles.
  - nr_sel=11 -> 14 rounds.
  - Toggling nr_sel during RUN changes nothing.
- **Backpressure:** out_ready=0 for 5 cycles in DONE, in_valid=1 throughout ->
  - dataout stable and in_ready=0 for all 5 cycles;
  - on out_ready=1 the new block is accepted on that same edge and round_idx=1 next cycle.
- **Back-to-back:** in_valid and out_ready held high for 3 blocks (nr_sel=00) -> out_valid pulses every 11 cycles with no IDLE cycle between blocks.
- **Abort:** clr=1 at round_idx=5 -> next cycle fsm IDLE, state_out=0, round_idx=0, in_ready=1; no out_valid for the aborted block.

Source files
------------

// File: rtl/round_loop_mux.sv
// round_loop_mux: registered input/round-loop selector for an iterative AES
// datapath. Accepts a whitened block, loops it through the external round
// logic for 10/12/14 rounds and presents the result on an output handshake.
// The round index drives the key schedule. last_round tells the round logic
// to omit MixColumns.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high and clr is low. in_ready = IDLE | (DONE & out_ready), so a new
// block is accepted on the same edge that the finished block is consumed.
// out_valid stays high and dataout stays stable until out_ready is seen.
`timescale 1ns/1ps

module round_loop_mux #(
  parameter int WIDTH = 128,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] datain,
  input  logic [1:0]       nr_sel,
  output logic [WIDTH-1:0] state_out,
  input  logic [WIDTH-1:0] rnddata,
  output logic [CW-1:0]    round_idx,
  output logic             last_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataout,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] NR_MAX = CW'(14);
  localparam logic [CW-1:0] IDX_FIRST = CW'(1);

  // Round count for a block; the 11 encoding aliases AES-256.
  function automatic logic [CW-1:0] decode_nr(input logic [1:0] sel);
    logic [CW-1:0] nr;
    case (sel)
      2'b00:   nr = CW'(10);
      2'b01:   nr = CW'(12);
      default: nr = CW'(14);
    endcase
    return nr;
  endfunction

  state_t           fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    nr_q, nr_d;
  logic             at_last;

  assign at_last    = (idx_q == nr_q);
  assign in_ready   = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
  assign out_valid  = (fsm_q == DONE);
  assign last_round = (fsm_q == RUN) & at_last;
  assign state_out  = state_q;
  assign dataout    = state_q;
  assign round_idx  = idx_q;
  assign fsm_state  = fsm_q;

  // Next-state logic: clr overrides everything, then per-state loading/looping.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    nr_d    = nr_q;
    if (clr) begin
      fsm_d   = IDLE;
      state_d = '0;
      idx_d   = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            fsm_d   = RUN;
            state_d = datain;
            idx_d   = IDX_FIRST;
            nr_d    = decode_nr(nr_sel);
          end
        end
        RUN: begin
          // Round logic result always replaces the state while running.
          state_d = rnddata;
          if (at_last) begin
            fsm_d = DONE;
            idx_d = '0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              // Consume and accept on the same edge: no bubble.
              fsm_d   = RUN;
              state_d = datain;
              idx_d   = IDX_FIRST;
              nr_d    = decode_nr(nr_sel);
            end else begin
              fsm_d = IDLE;
            end
          end
        end
        default: begin
          fsm_d   = IDLE;
          state_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State, data and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      idx_q   <= '0;
      nr_q    <= NR_MAX;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      nr_q    <= nr_d;
    end
  end

endmodule

// File: tb/tb_round_loop_mux.sv
// Bench for round_loop_mux: directed blocks with hand-computed results,
// round logic modelled as state+1, output scoreboard with expected queues.
`timescale 1ns/1ps

module tb_round_loop_mux;

  localparam int W = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  datain;
  logic [1:0]    nr_sel;
  logic [W-1:0]  state_out;
  logic [W-1:0]  rnddata;
  logic [3:0]    round_idx;
  logic          last_round;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dataout;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           rise_q[$];

  round_loop_mux #(.WIDTH(W), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .datain(datain),
    .nr_sel(nr_sel), .state_out(state_out), .rnddata(rnddata),
    .round_idx(round_idx), .last_round(last_round),
    .out_valid(out_valid), .out_ready(out_ready), .dataout(dataout),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round logic model
  assign rnddata = state_out + 128'd1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present a block, wait for acceptance, record expectations
  task automatic send(input logic [W-1:0] d, input logic [1:0] sel,
                      input logic [W-1:0] exp, input int nr, output int acc);
    int n;
    n = 0;
    datain   = d;
    nr_sel   = sel;
    in_valid = 1'b1;
    #0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    check("accept_timeout", in_ready, 1);
    acc = cyc + 1;
    exp_q.push_back(exp);
    rise_q.push_back(acc + nr);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (fsm_state != 2'd0 && n < 60) begin
      tick();
      n++;
    end
    check("idle_timeout", fsm_state, 2'd0);
  endtask

  // monitor / scoreboard
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    int er;
    logic [W-1:0] ed;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (rise_q.size() == 0) check("unexpected_out_valid", out_valid, 0);
        else begin
          er = rise_q.pop_front();
          check("out_valid_latency", cyc, er);
        end
      end
      if (out_valid && out_ready && !clr) begin
        if (exp_q.size() == 0) check("unexpected_output", out_valid, 0);
        else begin
          ed = exp_q.pop_front();
          check("dataout", dataout, ed);
          check("state_out_eq", state_out, ed);
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, n;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    datain = '0; nr_sel = 2'b00;

    // reset values
    repeat (2) tick();
    check("rst_state_out", state_out, 0);
    check("rst_dataout", dataout, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_last_round", last_round, 0);
    check("rst_fsm", fsm_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // AES-256 run: 0x1000 + 14 rounds
    send(128'h1000, 2'b10, 128'h100E, 14, a1);
    in_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      check("aes256_round_idx", round_idx, k);
      check("aes256_last_round", last_round, (k == 14));
      tick();
    end
    check("aes256_out_valid", out_valid, 1);
    check("aes256_dataout", dataout, 128'h100E);
    check("aes256_idx_done", round_idx, 0);
    check("aes256_last_done", last_round, 0);
    wait_idle();

    // round-count modes
    send(128'h0, 2'b00, 128'hA, 10, a1);
    in_valid = 1'b0;
    wait_idle();
    send(128'h0, 2'b01, 128'hC, 12, a1);
    in_valid = 1'b0;
    wait_idle();
    send(128'h0, 2'b11, 128'hE, 14, a1);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      nr_sel = 2'(k);
      tick();
    end
    wait_idle();

    // backpressure: hold out_ready low in DONE with the next block waiting
    out_ready = 1'b0;
    send(128'h20, 2'b00, 128'h2A, 10, a1);
    datain = 128'h30; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp_done_timeout", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_dataout_stable", dataout, 128'h2A);
      check("bp_in_ready_low", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    send(128'h30, 2'b00, 128'h3A, 10, a1);
    in_valid = 1'b0;
    check("bp_round_idx_1", round_idx, 1);
    check("bp_state_loaded", state_out, 128'h30);
    wait_idle();

    // back-to-back blocks
    send(128'h100, 2'b00, 128'h10A, 10, a1);
    send(128'h200, 2'b00, 128'h20A, 10, a2);
    send(128'h300, 2'b00, 128'h30A, 10, a3);
    in_valid = 1'b0;
    check("b2b_spacing_1", a2 - a1, 11);
    check("b2b_spacing_2", a3 - a2, 11);
    wait_idle();

    // abort at round 5
    send(128'h40, 2'b00, 128'h4A, 10, a1);
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd5 && n < 20) begin
      tick();
      n++;
    end
    check("abort_reach_r5", round_idx, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    void'(exp_q.pop_back());
    void'(rise_q.pop_back());
    check("abort_fsm", fsm_state, 0);
    check("abort_state_out", state_out, 0);
    check("abort_round_idx", round_idx, 0);
    check("abort_in_ready", in_ready, 1);
    for (int k = 0; k < 15; k++) begin
      check("abort_no_out_valid", out_valid, 0);
      tick();
    end

    // clr coinciding with a DONE handshake and a waiting block: no transfer
    out_ready = 1'b0;
    send(128'h50, 2'b00, 128'h5A, 10, a1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("clr_done_timeout", out_valid, 1);
    out_ready = 1'b1; in_valid = 1'b1; datain = 128'h60; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    void'(exp_q.pop_back());
    check("clrhs_fsm", fsm_state, 0);
    check("clrhs_state_out", state_out, 0);
    check("clrhs_round_idx", round_idx, 0);
    tick();
    check("clrhs_no_accept", fsm_state, 0);

    // asynchronous reset mid-run at round 7
    send(128'h55, 2'b10, 128'h63, 14, a1);
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd7 && n < 20) begin
      tick();
      n++;
    end
    check("rst_reach_r7", round_idx, 7);
    #2;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    void'(rise_q.pop_back());
    check("midrst_state_out", state_out, 0);
    check("midrst_round_idx", round_idx, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_last_round", last_round, 0);
    check("midrst_fsm", fsm_state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("midrst_no_out_valid", out_valid, 0);
    end

    check("exp_q_empty", exp_q.size(), 0);
    check("rise_q_empty", rise_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
